// File: rtl/duck_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : duck_pkg
//  Brief    : Shared state encodings, colour constants and box-test helper
//             for the multi-duck light-gun target generator.
//  Revision : 1.0  initial release
// ============================================================================
package duck_pkg;

    // Per-duck life cycle
    typedef logic [1:0] duck_state_t;
    localparam duck_state_t c_DUCK_FLYING = 2'd0;
    localparam duck_state_t c_DUCK_HIT    = 2'd1;
    localparam duck_state_t c_DUCK_LANDED = 2'd2;

    // Light-gun sequencer
    typedef logic [1:0] gun_state_t;
    localparam gun_state_t c_GUN_IDLE  = 2'd0;
    localparam gun_state_t c_GUN_BLACK = 2'd1;
    localparam gun_state_t c_GUN_FLASH = 2'd2;
    localparam gun_state_t c_GUN_HELD  = 2'd3;

    // 6-bit RRGGBB colours
    localparam logic [5:0] c_RGB_BLACK  = 6'b000000;
    localparam logic [5:0] c_RGB_WHITE  = 6'b111111;
    localparam logic [5:0] c_RGB_FLYING = 6'b110000;
    localparam logic [5:0] c_RGB_DOWN   = 6'b001100;

    // Half-open box test; one extra bit keeps l+w from wrapping.
    function automatic logic in_box(input logic [9:0]  col,
                                    input logic [9:0]  row,
                                    input logic [9:0]  l,
                                    input logic [9:0]  t,
                                    input logic [10:0] w,
                                    input logic [10:0] h);
        return ({1'b0, col} >= {1'b0, l}) && ({1'b0, col} < ({1'b0, l} + w)) &&
               ({1'b0, row} >= {1'b0, t}) && ({1'b0, row} < ({1'b0, t} + h));
    endfunction

endpackage
`default_nettype wire

// File: rtl/duck_motion.sv
`default_nettype none
// ============================================================================
//  Module   : duck_motion
//  Brief    : One duck's FLYING/HIT/LANDED state machine with bouncing,
//             falling and timed respawn. All updates happen on frame_tick.
//  Revision : 1.0  initial release
// ============================================================================
module duck_motion
    import duck_pkg::*;
#(
    parameter int IDX           = 0,
    parameter int BOX_W         = 50,
    parameter int BOX_H         = 50,
    parameter int SCR_W         = 640,
    parameter int SCR_H         = 480,
    parameter int HS            = 5,
    parameter int VS            = 2,
    parameter int LANDED_FRAMES = 60
) (
    input  logic        clk,
    input  logic        screen_reset,
    input  logic        frame_tick_i,
    input  logic        hit_i,
    output duck_state_t state_o,
    output logic [9:0]  box_l_o,
    output logic [9:0]  box_t_o
);

    localparam logic [10:0] c_X_MAX     = 11'(SCR_W - BOX_W);
    localparam logic [10:0] c_Y_MAX     = 11'(SCR_H - BOX_H);
    localparam logic [10:0] c_HS        = 11'(HS);
    localparam logic [10:0] c_VS        = 11'(VS);
    localparam logic [9:0]  c_SPAWN_L   = 10'(IDX * 2 * BOX_W);
    localparam logic        c_SPAWN_FWD = ((IDX % 2) == 0);
    localparam int          c_CW        = (LANDED_FRAMES > 1) ? $clog2(LANDED_FRAMES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(LANDED_FRAMES - 1);

    duck_state_t     state_q, state_d;
    logic [9:0]      l_q, l_d, t_q, t_d;
    logic            fwd_q, fwd_d, down_q, down_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [10:0]     w_l_add, w_t_add;

    assign w_l_add = {1'b0, l_q} + c_HS;
    assign w_t_add = {1'b0, t_q} + c_VS;

    // Next-state: bounce while flying, fall when hit, count down when landed.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        t_d     = t_q;
        fwd_d   = fwd_q;
        down_d  = down_q;
        cnt_d   = cnt_q;
        if (frame_tick_i) begin
            case (state_q)
                c_DUCK_FLYING: begin
                    if (hit_i) begin
                        state_d = c_DUCK_HIT;
                    end else begin
                        if (fwd_q) begin
                            if (w_l_add >= c_X_MAX) begin
                                l_d   = c_X_MAX[9:0];
                                fwd_d = 1'b0;
                            end else begin
                                l_d = w_l_add[9:0];
                            end
                        end else if ({1'b0, l_q} < c_HS) begin
                            l_d   = 10'd0;
                            fwd_d = 1'b1;
                        end else begin
                            l_d = l_q - c_HS[9:0];
                        end
                        if (down_q) begin
                            if (w_t_add >= c_Y_MAX) begin
                                t_d    = c_Y_MAX[9:0];
                                down_d = 1'b0;
                            end else begin
                                t_d = w_t_add[9:0];
                            end
                        end else if ({1'b0, t_q} < c_VS) begin
                            t_d    = 10'd0;
                            down_d = 1'b1;
                        end else begin
                            t_d = t_q - c_VS[9:0];
                        end
                    end
                end
                c_DUCK_HIT: begin
                    if (w_t_add >= c_Y_MAX) begin
                        t_d     = c_Y_MAX[9:0];
                        state_d = c_DUCK_LANDED;
                        cnt_d   = '0;
                    end else begin
                        t_d = w_t_add[9:0];
                    end
                end
                c_DUCK_LANDED: begin
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = c_DUCK_FLYING;
                        l_d     = c_SPAWN_L;
                        t_d     = 10'd0;
                        fwd_d   = c_SPAWN_FWD;
                        down_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = c_DUCK_FLYING;
            endcase
        end
    end

    // State registers; reset places the duck at its spawn point.
    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            state_q <= c_DUCK_FLYING;
            l_q     <= c_SPAWN_L;
            t_q     <= 10'd0;
            fwd_q   <= c_SPAWN_FWD;
            down_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            t_q     <= t_d;
            fwd_q   <= fwd_d;
            down_q  <= down_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign box_l_o = l_q;
    assign box_t_o = t_q;

endmodule
`default_nettype wire

// File: rtl/multi_duck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_duck_gen
//  Brief    : Several independent duck targets, a light-gun flash sequencer
//             that tests one duck per flash frame, a hit score and the
//             registered pixel colour mux.
//  Revision : 1.0  initial release
// ============================================================================
module multi_duck_gen
    import duck_pkg::*;
#(
    parameter int NUM_DUCKS     = 2,
    parameter int BOX_W         = 50,
    parameter int BOX_H         = 50,
    parameter int SCR_W         = 640,
    parameter int SCR_H         = 480,
    parameter int HS_BASE       = 5,
    parameter int VS_BASE       = 2,
    parameter int LANDED_FRAMES = 60
) (
    input  logic       clk,
    input  logic       screen_reset,
    input  logic       frame_tick,
    input  logic       valid,
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  logic       trigger,
    input  logic       detect,
    input  logic [5:0] bg_rgb,
    output logic [5:0] rgb,
    output logic [7:0] score,
    output logic       flash_active
);

    localparam logic [1:0] c_LAST_FIDX = 2'(NUM_DUCKS - 1);

    gun_state_t gun_q, gun_d;
    logic [1:0] fidx_q, fidx_d;
    logic       latch_q, latch_d;
    logic [7:0] score_q, score_d;
    logic [5:0] rgb_q, rgb_d;

    duck_state_t          w_duck_state [NUM_DUCKS];
    logic [9:0]           w_box_l      [NUM_DUCKS];
    logic [9:0]           w_box_t      [NUM_DUCKS];
    logic [NUM_DUCKS-1:0] w_in_box, w_flying, w_sel, w_hit;
    logic                 w_flash_hit, w_sel_flying, w_sel_lit;

    // A flash frame ends with a hit if the photodiode saw light at any point.
    assign w_flash_hit  = frame_tick && (gun_q == c_GUN_FLASH) && (latch_q || detect);
    assign w_sel_flying = |(w_sel & w_flying);
    assign w_sel_lit    = |(w_sel & w_flying & w_in_box);

    for (genvar k = 0; k < NUM_DUCKS; k++) begin : g_duck
        duck_motion #(
            .IDX           (k),
            .BOX_W         (BOX_W),
            .BOX_H         (BOX_H),
            .SCR_W         (SCR_W),
            .SCR_H         (SCR_H),
            .HS            (HS_BASE + k),
            .VS            (VS_BASE + k),
            .LANDED_FRAMES (LANDED_FRAMES)
        ) u_duck (
            .clk          (clk),
            .screen_reset (screen_reset),
            .frame_tick_i (frame_tick),
            .hit_i        (w_hit[k]),
            .state_o      (w_duck_state[k]),
            .box_l_o      (w_box_l[k]),
            .box_t_o      (w_box_t[k])
        );
        assign w_sel[k]    = (fidx_q == 2'(k));
        assign w_flying[k] = (w_duck_state[k] == c_DUCK_FLYING);
        assign w_hit[k]    = w_flash_hit && w_sel[k];
        assign w_in_box[k] = in_box(col, row, w_box_l[k], w_box_t[k],
                                    11'(BOX_W), 11'(BOX_H));
    end

    // Gun sequencer, detect latch and saturating score.
    always_comb begin
        gun_d   = gun_q;
        fidx_d  = fidx_q;
        latch_d = latch_q;
        score_d = score_q;
        if ((gun_q == c_GUN_FLASH) && detect) begin
            latch_d = 1'b1;
        end
        if (frame_tick) begin
            latch_d = 1'b0;
            case (gun_q)
                c_GUN_IDLE: begin
                    if (trigger) gun_d = c_GUN_BLACK;
                end
                c_GUN_BLACK: begin
                    gun_d  = c_GUN_FLASH;
                    fidx_d = 2'd0;
                end
                c_GUN_FLASH: begin
                    if (w_flash_hit && w_sel_flying && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                    if (fidx_q < c_LAST_FIDX) begin
                        fidx_d = fidx_q + 2'd1;
                    end else begin
                        gun_d = c_GUN_HELD;
                    end
                end
                c_GUN_HELD: begin
                    if (!trigger) gun_d = c_GUN_IDLE;
                end
                default: gun_d = c_GUN_IDLE;
            endcase
        end
    end

    // Pixel colour: lowest duck index is painted last so it wins overlaps.
    always_comb begin
        rgb_d = bg_rgb;
        for (int k = NUM_DUCKS - 1; k >= 0; k--) begin
            if (w_in_box[k]) begin
                rgb_d = w_flying[k] ? c_RGB_FLYING : c_RGB_DOWN;
            end
        end
        if (gun_q == c_GUN_BLACK) begin
            rgb_d = c_RGB_BLACK;
        end else if (gun_q == c_GUN_FLASH) begin
            rgb_d = w_sel_lit ? c_RGB_WHITE : c_RGB_BLACK;
        end
        if (!valid) begin
            rgb_d = c_RGB_BLACK;
        end
    end

    // Registered state for gun, score and pixel output.
    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            gun_q   <= c_GUN_IDLE;
            fidx_q  <= 2'd0;
            latch_q <= 1'b0;
            score_q <= 8'd0;
            rgb_q   <= c_RGB_BLACK;
        end else begin
            gun_q   <= gun_d;
            fidx_q  <= fidx_d;
            latch_q <= latch_d;
            score_q <= score_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb          = rgb_q;
    assign score        = score_q;
    assign flash_active = (gun_q == c_GUN_BLACK) || (gun_q == c_GUN_FLASH);

endmodule
`default_nettype wire

// File: tb/tb_multi_duck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_duck_gen
//  Brief    : Directed self-checking bench for multi_duck_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_duck_gen;

    localparam int G_IDLE = 0, G_BLACK = 1, G_FLASH = 2, G_HELD = 3;
    localparam int D_FLY = 0, D_HIT = 1, D_LAND = 2;

    logic       clk = 1'b0;
    logic       screen_reset, frame_tick, valid, trigger, detect;
    logic [9:0] col, row;
    logic [5:0] bg_rgb, rgb;
    logic [7:0] score;
    logic       flash_active;

    logic       rst2, ft2, trig2, det2;
    logic [5:0] rgb2;
    logic [7:0] score2;
    logic       flash2;

    int checks   = 0;
    int failures = 0;

    // Reference model of the two default ducks
    int m_l [2], m_t [2], m_st [2], m_cnt [2];
    bit m_f [2], m_d [2];

    always #5 clk = ~clk;

    multi_duck_gen dut (
        .clk(clk), .screen_reset(screen_reset), .frame_tick(frame_tick),
        .valid(valid), .col(col), .row(row), .trigger(trigger), .detect(detect),
        .bg_rgb(bg_rgb), .rgb(rgb), .score(score), .flash_active(flash_active)
    );

    // Tiny screen, one duck, one landed frame: fast hit/respawn cycles
    multi_duck_gen #(.NUM_DUCKS(1), .SCR_H(50), .LANDED_FRAMES(1)) dut2 (
        .clk(clk), .screen_reset(rst2), .frame_tick(ft2),
        .valid(1'b0), .col(10'd0), .row(10'd0), .trigger(trig2), .detect(det2),
        .bg_rgb(6'd0), .rgb(rgb2), .score(score2), .flash_active(flash2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic respawn(input int k);
        m_l[k] = k * 100; m_t[k] = 0; m_d[k] = 1'b1; m_f[k] = (k % 2 == 0);
        m_st[k] = D_FLY; m_cnt[k] = 0;
    endtask

    task automatic model_step(input logic [1:0] hits);
        for (int k = 0; k < 2; k++) begin
            int hs, vs;
            hs = 5 + k; vs = 2 + k;
            case (m_st[k])
                D_FLY: begin
                    if (hits[k]) m_st[k] = D_HIT;
                    else begin
                        if (m_f[k]) begin
                            if (m_l[k] + hs >= 590) begin m_l[k] = 590; m_f[k] = 1'b0; end
                            else m_l[k] = m_l[k] + hs;
                        end else if (m_l[k] < hs) begin m_l[k] = 0; m_f[k] = 1'b1; end
                        else m_l[k] = m_l[k] - hs;
                        if (m_d[k]) begin
                            if (m_t[k] + vs >= 430) begin m_t[k] = 430; m_d[k] = 1'b0; end
                            else m_t[k] = m_t[k] + vs;
                        end else if (m_t[k] < vs) begin m_t[k] = 0; m_d[k] = 1'b1; end
                        else m_t[k] = m_t[k] - vs;
                    end
                end
                D_HIT: begin
                    if (m_t[k] + vs >= 430) begin m_t[k] = 430; m_st[k] = D_LAND; m_cnt[k] = 0; end
                    else m_t[k] = m_t[k] + vs;
                end
                default: begin
                    if (m_cnt[k] == 59) respawn(k);
                    else m_cnt[k]++;
                end
            endcase
        end
    endtask

    function automatic bit m_in(input int k, input int c, input int r);
        return (c >= m_l[k]) && (c < m_l[k] + 50) && (r >= m_t[k]) && (r < m_t[k] + 50);
    endfunction

    function automatic logic [5:0] exp_pix(input int gun, input int fidx, input int c, input int r);
        logic [5:0] res;
        if (gun == G_BLACK) return 6'b000000;
        if (gun == G_FLASH) return (m_in(fidx, c, r) && m_st[fidx] == D_FLY) ? 6'b111111 : 6'b000000;
        res = bg_rgb;
        for (int k = 1; k >= 0; k--)
            if (m_in(k, c, r)) res = (m_st[k] == D_FLY) ? 6'b110000 : 6'b001100;
        return res;
    endfunction

    // One frame_tick clock followed by one quiet clock; returns on a negedge.
    task automatic tick(input logic [1:0] hits);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_step(hits);
        @(negedge clk);
    endtask

    task automatic tick2();
        ft2 = 1'b1;
        @(negedge clk);
        ft2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_ducks(input string tag);
        check({tag, "_d0_st"}, 32'(dut.g_duck[0].u_duck.state_o), m_st[0]);
        check({tag, "_d0_l"},  32'(dut.g_duck[0].u_duck.box_l_o), m_l[0]);
        check({tag, "_d0_t"},  32'(dut.g_duck[0].u_duck.box_t_o), m_t[0]);
        check({tag, "_d1_st"}, 32'(dut.g_duck[1].u_duck.state_o), m_st[1]);
        check({tag, "_d1_l"},  32'(dut.g_duck[1].u_duck.box_l_o), m_l[1]);
        check({tag, "_d1_t"},  32'(dut.g_duck[1].u_duck.box_t_o), m_t[1]);
    endtask

    task automatic probe(input string tag, input int c, input int r, input int gun, input int fidx);
        col = 10'(c); row = 10'(r); valid = 1'b1;
        @(negedge clk);
        check(tag, 32'(rgb), 32'(exp_pix(gun, fidx, c, r)));
        valid = 1'b0;
    endtask

    initial begin
        bit done, seen_land;
        int nflash;
        screen_reset = 1'b1; frame_tick = 1'b0; valid = 1'b0; trigger = 1'b0;
        detect = 1'b0; col = '0; row = '0; bg_rgb = 6'b000011;
        rst2 = 1'b1; ft2 = 1'b0; trig2 = 1'b0; det2 = 1'b0;
        respawn(0); respawn(1);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_score", 32'(score), 0);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_flash", 32'(flash_active), 0);
        check("rst_gun", 32'(dut.gun_q), G_IDLE);
        check_ducks("rst");
        screen_reset = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Free flight: duck 0 steps by 5, reverses at 590, never wraps
        for (int i = 0; i < 130; i++) begin
            tick(2'b00);
            check_ducks("fly");
            if (i == 117) check("d0_at_590", 32'(dut.g_duck[0].u_duck.box_l_o), 590);
            if (i == 118) check("d0_rev_585", 32'(dut.g_duck[0].u_duck.box_l_o), 585);
        end
        probe("pix_d0_red", m_l[0] + 1, m_t[0] + 1, G_IDLE, 0);
        probe("pix_bg", 10, 10, G_IDLE, 0);
        col = 10'(m_l[0] + 1); row = 10'(m_t[0] + 1); valid = 1'b0;
        @(negedge clk);
        check("pix_invalid", 32'(rgb), 0);

        // Single trigger; light seen only during the flash for duck 1
        trigger = 1'b1;
        tick(2'b00);
        check("b_gun_black", 32'(dut.gun_q), G_BLACK);
        check("b_flash_act", 32'(flash_active), 1);
        trigger = 1'b0;
        probe("b_pix_black", m_l[0] + 1, m_t[0] + 1, G_BLACK, 0);
        tick(2'b00);
        check("b_gun_f0", 32'(dut.gun_q), G_FLASH);
        check("b_fidx0", 32'(dut.fidx_q), 0);
        tick(2'b00);
        check("b_fidx1", 32'(dut.fidx_q), 1);
        check("b_flash_act1", 32'(flash_active), 1);
        probe("b_pix_white_d1", m_l[1] + 1, m_t[1] + 1, G_FLASH, 1);
        probe("b_pix_dark_d0", m_l[0] + 1, m_t[0] + 1, G_FLASH, 1);
        detect = 1'b1;
        @(negedge clk);
        detect = 1'b0;
        tick(2'b10);
        check("b_gun_held", 32'(dut.gun_q), G_HELD);
        check("b_score1", 32'(score), 1);
        check("b_flash_off", 32'(flash_active), 0);
        check_ducks("b_hit");

        // Hit duck falls, lands for 60 frames and respawns
        done = 1'b0; seen_land = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick(2'b00);
            if (i == 0) check("c_gun_idle", 32'(dut.gun_q), G_IDLE);
            check_ducks("fall");
            if (m_st[1] == D_LAND && !seen_land) begin
                seen_land = 1'b1;
                check("c_land_t", 32'(dut.g_duck[1].u_duck.box_t_o), 430);
                probe("c_pix_landed", m_l[1] + 1, m_t[1] + 1, G_IDLE, 0);
            end
            if (seen_land && m_st[1] == D_FLY) done = 1'b1;
        end
        check("c_respawned", 32'(done), 1);
        check("c_resp_l", 32'(dut.g_duck[1].u_duck.box_l_o), 100);
        check("c_resp_t", 32'(dut.g_duck[1].u_duck.box_t_o), 0);
        probe("c_pix_red_again", 101, 1, G_IDLE, 0);
        check("c_score_kept", 32'(score), 1);

        // Trigger held: one BLACK, two FLASH, then HELD until release
        trigger = 1'b1;
        nflash = 0;
        for (int i = 0; i < 10; i++) begin
            tick(2'b00);
            if (flash_active) nflash++;
            check("d_gun_seq", 32'(dut.gun_q),
                  (i == 0) ? G_BLACK : (i <= 2) ? G_FLASH : G_HELD);
        end
        check("d_nflash", nflash, 3);
        trigger = 1'b0;
        tick(2'b00);
        check("d_gun_idle", 32'(dut.gun_q), G_IDLE);
        check("d_score_same", 32'(score), 1);
        check_ducks("d");

        // Score saturation on the small instance
        det2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            trig2 = 1'b1;
            tick2();
            trig2 = 1'b0;
            tick2();
            tick2();
            tick2();
            if (i == 0)   check("e_score2_1", 32'(score2), 1);
            if (i == 254) check("e_score2_255", 32'(score2), 255);
        end
        check("e_score2_sat", 32'(score2), 255);
        check("e_gun2_idle", 32'(dut2.gun_q), G_IDLE);
        det2 = 1'b0;

        // Reset in the middle of a flash
        trigger = 1'b1;
        tick(2'b00);
        trigger = 1'b0;
        tick(2'b00);
        probe("f_pix_white", m_l[0] + 1, m_t[0] + 1, G_FLASH, 0);
        col = 10'(m_l[0] + 1); row = 10'(m_t[0] + 1); valid = 1'b1;
        detect = 1'b1;
        @(negedge clk);
        check("f_rgb_before", 32'(rgb), 6'b111111);
        #2 screen_reset = 1'b1;
        #1;
        check("f_rst_gun", 32'(dut.gun_q), G_IDLE);
        check("f_rst_fidx", 32'(dut.fidx_q), 0);
        check("f_rst_score", 32'(score), 0);
        check("f_rst_rgb", 32'(rgb), 0);
        check("f_rst_flash", 32'(flash_active), 0);
        @(negedge clk);
        screen_reset = 1'b0; detect = 1'b0; valid = 1'b0;
        respawn(0); respawn(1);
        check_ducks("f_rst");
        tick(2'b00);
        check("f_score_after", 32'(score), 0);
        check("f_gun_after", 32'(dut.gun_q), G_IDLE);
        check_ducks("f_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
